// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit flip-flop bank.
// One requester is granted at a time. Its DIN slice is captured into the bank
// on the GRANT exit edge, then ACK is pulsed in DONE.
// Optional feature macro: DFF_ARB_LOCK_EN. It adds the LOCK input, which lets
// the owner run back-to-back bursts that skip IDLE.
module dff_bank_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] DIN,
`ifdef DFF_ARB_LOCK_EN
    input  logic [NREQ-1:0]       LOCK,
`endif
    output logic [NREQ-1:0]       GNT,
    output logic                  ACK,
    output logic [OW-1:0]         OWNER,
    output logic [WIDTH-1:0]      Q,
    output logic [WIDTH-1:0]      invQ
);

    typedef enum logic [1:0] {StIdle, StGrant, StDone} state_e;

    state_e            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  q_q, q_d;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [OW:0]       rr_sum;
    logic [OW-1:0]     rr_pick;
    logic [WIDTH-1:0]  din_sel;
    logic [OW-1:0]     ptr_next;

    // Round-robin search: rotate REQ so PTR sits at bit 0, take the lowest set bit.
    always_comb begin
        req_dbl = {REQ, REQ} >> ptr_q;
        req_rot = req_dbl[NREQ-1:0];
        rr_sum  = '0;
        rr_pick = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rr_sum  = {1'b0, ptr_q} + (OW+1)'(k);
                rr_pick = (rr_sum >= (OW+1)'(NREQ)) ? OW'(rr_sum - (OW+1)'(NREQ))
                                                    : OW'(rr_sum);
            end
        end
    end

    // Select the owner's data slice and the post-service priority pointer.
    always_comb begin
        din_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                din_sel = DIN[i*WIDTH +: WIDTH];
            end
        end
        ptr_next = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // State and bank registers; synchronous reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
        end
    end

    // Next-state logic; the bank only loads on the GRANT exit edge.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        q_d     = q_q;
        unique case (state_q)
            StIdle: begin
                if (|REQ) begin
                    owner_d = rr_pick;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                q_d     = din_sel;
                ptr_d   = ptr_next;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
`ifdef DFF_ARB_LOCK_EN
                // Locked owner keeps the bank. PTR was already advanced and is
                // used once the lock releases.
                if (LOCK[owner_q] && REQ[owner_q]) begin
                    state_d = StGrant;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only; REQ has no path to GNT.
    always_comb begin
        GNT = '0;
        if (state_q == StGrant) begin
            GNT[owner_q] = 1'b1;
        end
        ACK   = (state_q == StDone);
        OWNER = owner_q;
        Q     = q_q;
        invQ  = ~q_q;
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter (NREQ=4, WIDTH=8): directed scenarios followed by
// random traffic. All results are compared against a cycle-level reference model.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        ack;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic [7:0]  invq;
`ifdef DFF_ARB_LOCK_EN
    logic [3:0]  lock;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = idle, 1 = granting, 2 = acknowledging.
    int          m_state = 0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    logic [7:0]  m_q     = 8'h00;

    always #5 clk = ~clk;

    dff_bank_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) u_dut (
        .CLK   (clk),
        .RST   (rst),
        .REQ   (req),
        .DIN   (din),
`ifdef DFF_ARB_LOCK_EN
        .LOCK  (lock),
`endif
        .GNT   (gnt),
        .ACK   (ack),
        .OWNER (owner),
        .Q     (q),
        .invQ  (invq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        if (rst) begin
            m_state = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_q     = 8'h00;
        end else begin
            case (m_state)
                0: begin
                    if (req != 4'b0000) begin
                        for (int k = NREQ - 1; k >= 0; k--) begin
                            if (req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
                        end
                        m_state = 1;
                    end
                end
                1: begin
                    m_q     = din[m_owner*WIDTH +: WIDTH];
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_state = 2;
                end
                default: begin
                    m_state = 0;
`ifdef DFF_ARB_LOCK_EN
                    if (lock[m_owner] && req[m_owner]) m_state = 1;
`endif
                end
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_gnt;
        logic [7:0] e_inv;
        e_gnt = 4'b0000;
        if (m_state == 1) e_gnt[m_owner] = 1'b1;
        e_inv = ~m_q;
        check_eq({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        check_eq({tag, ".ack"},   32'(ack),   32'(m_state == 2));
        check_eq({tag, ".owner"}, 32'(owner), 32'(m_owner));
        check_eq({tag, ".q"},     32'(q),     32'(m_q));
        check_eq({tag, ".invq"},  32'(invq),  32'(e_inv));
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [3:0] grants[$];
        logic [3:0] exp_rot[4];
        int         lock_gnt0;

        rst = 1'b1;
        req = 4'b1111;
        din = $urandom;
`ifdef DFF_ARB_LOCK_EN
        lock = 4'b0000;
`endif

        // Reset held two cycles with all requests high.
        tick("reset0");
        tick("reset1");
        check_eq("reset_q", 32'(q), 32'h00);
        check_eq("reset_invq", 32'(invq), 32'hFF);
        check_eq("reset_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        tick("release");
        check_eq("release_gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        tick("release_done");
        tick("release_idle");

        // Single requester 2.
        req = 4'b0100;
        din = $urandom;
        din[23:16] = 8'hA5;
        tick("single_g");
        check_eq("single_gnt", 32'(gnt), 32'b0100);
        tick("single_d");
        check_eq("single_q", 32'(q), 32'hA5);
        check_eq("single_invq", 32'(invq), 32'h5A);
        check_eq("single_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        tick("single_idle");
        check_eq("single_idle_ack", 32'(ack), 32'h0);

        // Rotation from a fresh pointer with all requests held for 12 cycles.
        rst = 1'b1;
        tick("rot_rst");
        rst = 1'b0;
        req = 4'b1111;
        din = $urandom;
        for (int c = 0; c < 12; c++) begin
            tick("rot");
            if (gnt != 4'b0000) grants.push_back(gnt);
        end
        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        check_eq("rot_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check_eq("rot_order", 32'(grants[i]), 32'(exp_rot[i]));
        end

        // Requester 3 was served last, so requester 0 wins over 3.
        req = 4'b1001;
        tick("wrap");
        check_eq("wrap_gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        tick("wrap_d");
        tick("wrap_i");

        // Reset hits during the GRANT cycle of requester 1.
        req = 4'b0010;
        din = $urandom;
        din[15:8] = 8'h3C;
        tick("midrst_g");
        check_eq("midrst_gnt", 32'(gnt), 32'b0010);
        rst = 1'b1;
        tick("midrst_r");
        check_eq("midrst_q", 32'(q), 32'h00);
        check_eq("midrst_ack", 32'(ack), 32'h0);
        rst = 1'b0;
        req = 4'b0000;
        tick("midrst_i");
        check_eq("midrst_ack2", 32'(ack), 32'h0);
        check_eq("midrst_gnt2", 32'(gnt), 32'h0);

`ifdef DFF_ARB_LOCK_EN
        // Locked burst for requester 1 while requester 0 waits.
        lock = 4'b0010;
        req  = 4'b0010;
        din[15:8] = 8'h11;
        tick("lock_first");
        req = 4'b0011;
        lock_gnt0 = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) din[15:8] = 8'h22;
            tick("lock_burst");
            if (gnt[0]) lock_gnt0++;
        end
        check_eq("lock_no_gnt0", 32'(lock_gnt0), 32'd0);
        check_eq("lock_q", 32'(q), 32'h22);
        lock = 4'b0000;
        for (int c = 0; c < 4; c++) tick("lock_release");
`else
        lock_gnt0 = 0;
`endif

        // Random traffic, including occasional resets.
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            req = 4'($urandom);
            din = $urandom;
`ifdef DFF_ARB_LOCK_EN
            lock = 4'($urandom);
`endif
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop storage bank (Q/invQ pair per bit).
- NREQ requesters compete to load the bank. The block grants one requester at a time, captures its data into the bank, then acknowledges.
- Sits between requester logic and the flip-flop storage. It is the only writer of the bank.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, storage bank width in bits; legal range 1..32.
- OW (localparam), clog2(NREQ), width of OWNER; minimum 1.

Ports:
- CLK  input  1  rising-edge clock, single clock domain
- RST  input  1  synchronous reset, active-high
- REQ  input  NREQ  per-requester write request, level
- DIN  input  NREQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- GNT  output  NREQ  one-hot grant, high only in GRANT state
- ACK  output  1  write-complete strobe, high only in DONE state
- OWNER  output  OW  index of current or last granted requester
- Q  output  WIDTH  stored bank value
- invQ  output  WIDTH  always bitwise ~Q, never independently registered

Behaviour:
- Clocking and reset: one clock (CLK). RST is synchronous and active-high; it is sampled on the CLK rising edge and overrides everything.
- Reset values: state=IDLE, Q=0, invQ=all ones, GNT=0, ACK=0, OWNER=0, round-robin pointer PTR=0.
- FSM states: IDLE, GRANT, DONE. All outputs are registered or decoded from state; no combinational path from REQ to GNT.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise, search from index PTR upward with wrap to find the first i where REQ[i]=1.
  - Next edge: OWNER<=i, state<=GRANT.
- GRANT (exactly 1 cycle):
  - GNT[OWNER]=1.
  - On exit edge: Q<=DIN[OWNER*WIDTH +: WIDTH], PTR<=(OWNER+1) mod NREQ, state<=DONE.
- DONE (exactly 1 cycle):
  - ACK=1. Q already holds the new value.
  - Next edge: state<=IDLE (see Optional Feature).
- Latency: REQ seen in IDLE -> GNT next cycle -> Q valid and ACK the cycle after. Request-to-ACK is 2 cycles; sustained throughput is one write per 3 cycles.
- Requester contract: hold REQ and DIN stable until ACK; deassert REQ in the ACK cycle or later.
  - REQ dropped during GRANT: the write is already committed; data sampled that cycle is stored and ACK still fires.
  - REQ still high after ACK: treated as a new request in the next IDLE.
- Fairness: the just-served requester becomes lowest priority. With all REQ high, the service order is 0,1,2,...,NREQ-1,0,...
- PTR wrap: PTR=NREQ-1 after serving the top requester wraps to 0.
- Reset during GRANT or DONE: returns to IDLE with Q cleared. No ACK is issued and no write completes.
- Q is held in all states except the GRANT exit edge.

Optional Feature:
- Macro: DFF_ARB_LOCK_EN.
- Defined:
  - Adds input port LOCK, width NREQ.
  - In DONE, if LOCK[OWNER]&&REQ[OWNER], next state is GRANT for the same OWNER, skipping IDLE. PTR update is still computed but ignored while locked.
  - Locked burst throughput: one write per 2 cycles. Lock is released when either LOCK or REQ of the owner drops in DONE.
- Undefined: the LOCK port does not exist and DONE always goes to IDLE.

Test Plan (NREQ=4, WIDTH=8):
- Reset: assert RST 2 cycles with REQ=4'b1111 -> Q=8'h00, invQ=8'hFF, GNT=0, ACK=0, OWNER=0; then deassert RST -> GNT=4'b0001 one cycle later.
- Single requester: REQ=4'b0100, DIN[23:16]=8'hA5 -> GNT=4'b0100 at cycle+1; Q=8'hA5, invQ=8'h5A, ACK=1 at cycle+2; IDLE at cycle+3.
- Rotation: REQ=4'b1111 held for 12 cycles -> GNT sequence 0001,0010,0100,1000, one grant every 3 cycles, with the correct DIN slice stored each time.
- Wrap priority: serve requester 3, then REQ=4'b1001 -> next grant goes to 0, not 3.
- Reset mid-op: RST asserted in the GRANT cycle for requester 1 (DIN=8'h3C) -> Q stays 8'h00, ACK never asserted, state IDLE.
- With DFF_ARB_LOCK_EN: LOCK=4'b0010, REQ=4'b0011, DIN for requester 1 changing 8'h11->8'h22 -> consecutive GRANT/DONE pairs for owner 1 every 2 cycles; requester 0 is not granted until LOCK[1] drops.
